byte_bus_sequencer: RTL

Sequences the core's 32-bit load/store requests onto the 8-bit external pin bus (uo_out address, uio data, uio_oe write enable) one byte per transfer.
Handles byte, half and word sizes, little-endian byte order, and sign/zero extension of loads. Returns a single response per request; the core stalls until that response arrives.
Sits between the cpu load/store path and the top-level pin mapping.

---
 rtl/riscv_bus_pkg.sv | 19 +
 rtl/byte_bus_sequencer_load_extender.sv | 26 ++
 rtl/byte_bus_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/riscv_bus_pkg.sv
// Shared types for the core's byte-serial external bus path.
package riscv_bus_pkg;

   typedef enum logic [1:0] {
      Byte     = 2'd0,
      Half     = 2'd1,
      Word     = 2'd2,
      Reserved = 2'd3
   } access_size_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRANSFER = 2'd1,
      RESPOND  = 2'd2
   } sequencer_state_t;

   localparam int BusByteWidth = 8;

endpackage

// File: rtl/byte_bus_sequencer_load_extender.sv
// Sign/zero extension of a little-endian load result to 32 bits.
module load_extender
   import riscv_bus_pkg::*;
(
   input  logic [31:0]  raw,
   input  access_size_t size,
   input  logic         is_unsigned,
   output logic [31:0]  extended
);

   logic fill_byte;
   logic fill_half;

   assign fill_byte = ~is_unsigned & raw[7];
   assign fill_half = ~is_unsigned & raw[15];

   always_comb begin
      extended = raw;
      case (size)
         Byte:    extended = {{24{fill_byte}}, raw[7:0]};
         Half:    extended = {{16{fill_half}}, raw[15:0]};
         default: extended = raw;
      endcase
   end

endmodule

// File: rtl/byte_bus_sequencer.sv
// Serialises 32-bit load/store requests onto an 8-bit external bus, one byte
// per transfer, little-endian, with a single response per request.
module byte_bus_sequencer
   import riscv_bus_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     request_valid,
   output logic                     request_ready,
   input  logic                     request_write,
   input  logic [1:0]               request_size,
   input  logic                     request_unsigned,
   input  logic [ADDRESS_WIDTH-1:0] request_address,
   input  logic [DATA_WIDTH-1:0]    request_write_data,
   output logic                     response_valid,
   output logic                     response_error,
   output logic [DATA_WIDTH-1:0]    response_read_data,
   output logic                     busy,
   output logic [ADDRESS_WIDTH-1:0] bus_address,
   output logic                     bus_write_enable,
   output logic [BusByteWidth-1:0]  bus_write_data,
   input  logic [BusByteWidth-1:0]  bus_read_data,
   input  logic                     bus_ready
);

   sequencer_state_t state, state_next;

   logic                     lat_write;
   access_size_t             lat_size;
   logic                     lat_unsigned;
   logic [ADDRESS_WIDTH-1:0] lat_address;
   logic [DATA_WIDTH-1:0]    lat_write_data;
   logic                     lat_error;
   logic [1:0]               index;
   logic [1:0]               last;
   logic [DATA_WIDTH-1:0]    capture;
   logic [DATA_WIDTH-1:0]    extended;

   logic accept;
   logic byte_done;

   assign accept    = (state == IDLE) && request_valid;
   assign byte_done = (state == TRANSFER) && bus_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (request_valid)
               state_next = (access_size_t'(request_size) == Reserved) ? RESPOND : TRANSFER;
         end
         TRANSFER: begin
            if (bus_ready && (index == last)) state_next = RESPOND;
         end
         RESPOND:  state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Request latch, byte index and load capture register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_write      <= 1'b0;
         lat_size       <= Byte;
         lat_unsigned   <= 1'b0;
         lat_address    <= '0;
         lat_write_data <= '0;
         lat_error      <= 1'b0;
         index          <= 2'd0;
         last           <= 2'd0;
         capture        <= '0;
      end else if (accept) begin
         lat_write      <= request_write;
         lat_size       <= access_size_t'(request_size);
         lat_unsigned   <= request_unsigned;
         lat_address    <= request_address;
         lat_write_data <= request_write_data;
         lat_error      <= (access_size_t'(request_size) == Reserved);
         index          <= 2'd0;
         case (access_size_t'(request_size))
            Byte:    last <= 2'd0;
            Half:    last <= 2'd1;
            default: last <= 2'd3;
         endcase
         capture        <= '0;
      end else if (byte_done) begin
         if (!lat_write) capture[{index, 3'b000} +: BusByteWidth] <= bus_read_data;
         if (index != last) index <= index + 2'd1;
      end
   end

   load_extender u_load_extender (
      .raw         (capture),
      .size        (lat_size),
      .is_unsigned (lat_unsigned),
      .extended    (extended)
   );

   // Outputs decode from state and latched registers only.
   always_comb begin
      request_ready      = (state == IDLE);
      busy               = (state != IDLE);
      response_valid     = (state == RESPOND);
      response_error     = (state == RESPOND) && lat_error;
      response_read_data = '0;
      bus_address        = '0;
      bus_write_enable   = 1'b0;
      bus_write_data     = '0;
      if (state == TRANSFER) begin
         bus_address      = lat_address + {{(ADDRESS_WIDTH-2){1'b0}}, index};
         bus_write_enable = lat_write;
         if (lat_write) bus_write_data = lat_write_data[{index, 3'b000} +: BusByteWidth];
      end
      if ((state == RESPOND) && !lat_write && !lat_error)
         response_read_data = extended;
   end

endmodule
